// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC sample capture block: state encodings,
// sample width and the threshold-crossing test.
package adc_capture_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } cap_state_t;

  // Crossing across the time-ordered samples prev_fall -> rise -> fall.
  // slope 0: below level then at/above; slope 1: above level then at/below.
  function automatic logic crossing(input logic                slope,
                                    input logic [SAMPLE_W-1:0] level,
                                    input logic [SAMPLE_W-1:0] prev_fall,
                                    input logic [SAMPLE_W-1:0] rise,
                                    input logic [SAMPLE_W-1:0] fall);
    if (!slope)
      crossing = ((prev_fall < level) && (rise >= level)) ||
                 ((rise < level) && (fall >= level));
    else
      crossing = ((prev_fall > level) && (rise <= level)) ||
                 ((rise > level) && (fall <= level));
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer, one write port, one registered read port
// (1-cycle latency). Read output holds while re is low, which the readout
// path relies on to keep rd_data stable during back-pressure.
module adc_capture_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rq
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Registered read port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) rq <= mem[ra];
  end

endmodule

// File: rtl/adc_sample_capture.sv
// Triggered capture of DDR ADC sample pairs into a DEPTH-word buffer, then
// valid/ready readout in write order.
// Optional feature: define ADC_CAPTURE_TIMESTAMP_EN to add a 32-bit
// free-running cycle counter and the trig_time output. The counter reads N
// in the Nth cycle after reset release; trig_time latches it in the cycle the
// trigger is evaluated, which is one cycle after the triggering pair appeared
// on sample_rise/sample_fall (the S1 register offset is +1 cycle).
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                adc_dco_clk,
  input  logic                adc_reset_n,
  input  logic [SAMPLE_W-1:0] sample_rise,
  input  logic [SAMPLE_W-1:0] sample_fall,
  input  logic                arm,
  input  logic                force_trig,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  output logic [15:0]         rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic [1:0]          state
`ifdef ADC_CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]         trig_time
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  cap_state_t st_q, st_d;

  logic [SAMPLE_W-1:0] s1_rise, s1_fall, prev_fall;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                issued_all;
  logic                trig, wr_en, rd_en;
  logic [15:0]         ram_q;

  assign trig  = force_trig | crossing(trig_slope, trig_level, prev_fall, s1_rise, s1_fall);
  assign state = st_q;

  // Input stage S1 plus previous fall sample; runs in every state.
  always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      s1_rise   <= '0;
      s1_fall   <= '0;
      prev_fall <= '0;
    end else begin
      s1_rise   <= sample_rise;
      s1_fall   <= sample_fall;
      prev_fall <= s1_fall;
    end
  end

  // State register.
  always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) st_q <= ST_IDLE;
    else              st_q <= st_d;
  end

  // Next state and buffer port enables.
  always_comb begin
    st_d  = st_q;
    wr_en = 1'b0;
    rd_en = 1'b0;
    case (st_q)
      ST_IDLE:    if (arm) st_d = ST_ARMED;
      ST_ARMED:   if (trig) begin
                    st_d  = ST_CAPTURE;
                    wr_en = 1'b1;
                  end
      ST_CAPTURE: begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST_ADDR) st_d = ST_READOUT;
                  end
      ST_READOUT: begin
                    // Fetch the next word whenever the output slot is empty
                    // or is being emptied this cycle.
                    rd_en = !issued_all && (!rd_valid || rd_ready);
                    if (rd_valid && rd_ready && rd_last) st_d = ST_IDLE;
                  end
      default:    st_d = ST_IDLE;
    endcase
  end

  // Write address; wraps to 0 after the last word of a frame.
  always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
    if (!adc_reset_n)  wr_addr <= '0;
    else if (wr_en)    wr_addr <= wr_addr + 1'b1;
  end

  // Readout control: the RAM output register is the output data register,
  // rd_valid/rd_last track what it currently holds.
  always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      rd_addr    <= '0;
      issued_all <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else if (rd_en) begin
      rd_addr    <= rd_addr + 1'b1;
      issued_all <= (rd_addr == LAST_ADDR);
      rd_valid   <= 1'b1;
      rd_last    <= (rd_addr == LAST_ADDR);
    end else if (rd_valid && rd_ready) begin
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      issued_all <= 1'b0;
    end
  end

  // Gate the RAM output so rd_data reads zero out of reset and when idle.
  assign rd_data = rd_valid ? ram_q : 16'h0000;

  adc_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (16)
  ) u_ram (
    .clk (adc_dco_clk),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  ({s1_fall, s1_rise}),
    .re  (rd_en),
    .ra  (rd_addr),
    .rq  (ram_q)
  );

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter and trigger timestamp latch.
  always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      cyc_cnt   <= '0;
      trig_time <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (st_q == ST_ARMED && trig) trig_time <= cyc_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_capture.sv
// Randomized scoreboard bench for adc_sample_capture. Each scenario builds a
// per-cycle stream of sample pairs, predicts the trigger point and the
// captured frame from it, and a monitor checks every transferred word.
module tb_adc_sample_capture;

  localparam int DEPTH = 256;
  localparam int L     = 700;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  srise = '0, sfall = '0, lvl = 8'h80;
  logic        arm = 1'b0, force_t = 1'b0, slope = 1'b0, rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_last;
  logic [1:0]  state;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
  logic [31:0] trig_time;
  int          edges;
  logic [31:0] exp_tt;
`endif

  adc_sample_capture #(.DEPTH(DEPTH)) dut (
    .adc_dco_clk (clk),
    .adc_reset_n (rst_n),
    .sample_rise (srise),
    .sample_fall (sfall),
    .arm         (arm),
    .force_trig  (force_t),
    .trig_level  (lvl),
    .trig_slope  (slope),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_last     (rd_last),
    .state       (state)
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    ,
    .trig_time   (trig_time)
`endif
  );

  always #5 clk = ~clk;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  // Cycles elapsed since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0, n_pass = 0;
  logic [7:0] p_r[L], p_f[L];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Level crossing anywhere along the time-ordered samples a -> b -> c.
  function automatic bit xing(input logic sl, input logic [7:0] lv,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] s[3];
    s[0] = a; s[1] = b; s[2] = c;
    xing = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!sl && s[i] < lv && s[i+1] >= lv) xing = 1'b1;
      if ( sl && s[i] > lv && s[i+1] <= lv) xing = 1'b1;
    end
  endfunction

  // Monitor: pops the scoreboard on every transfer, checks hold under stall
  // and the end-of-frame return to idle.
  bit          stall_prev = 0, last_prev = 0;
  logic [15:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
      last_prev  = 0;
    end else begin
      if (stall_prev) begin
        chk(rd_valid, "valid_dropped_in_stall", 32'(rd_valid), 32'd1);
        chk(rd_data == hold_data && rd_last == hold_last, "stall_hold",
            {15'd0, rd_last, rd_data}, {15'd0, hold_last, hold_data});
      end
      if (last_prev)
        chk(!rd_valid && state == 2'd0, "after_last_idle",
            {29'd0, rd_valid, state}, 32'd0);
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) chk(1'b0, "unexpected_word", {15'd0, rd_last, rd_data}, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk(rd_data == e.data && rd_last == e.last, "word",
              {15'd0, rd_last, rd_data}, {15'd0, e.last, e.data});
        end
      end
      stall_prev = rd_valid && !rd_ready;
      last_prev  = rd_valid && rd_ready && rd_last;
      hold_data  = rd_data;
      hold_last  = rd_last;
    end
  end

  // One capture scenario over the p_r/p_f stream (cycle 0 = first driven).
  // a: arm cycle, f: force cycle (-1 none), rst_word: reset while word
  // rst_word is written (-1 none), rnd_ready: randomize rd_ready.
  task automatic run_scn(input int a, input int f, input int rst_word, input bit rnd_ready,
                         input logic [7:0] level, input logic sl);
    int k, rst_at, exp_st;
    lvl   = level;
    slope = sl;
    // Reference: first pair k (from the arm cycle on) that completes a
    // crossing, or whose successor cycle carries force_trig.
    k = -1;
    for (int c = a; c < L - DEPTH; c++)
      if (xing(sl, level, p_f[c-1], p_r[c], p_f[c]) || f == c + 1) begin
        k = c;
        break;
      end
    if (k < 0) begin
      chk(1'b0, "model_trigger_found", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < DEPTH; i++) sb.push_back({p_f[k+i], p_r[k+i], i == DEPTH - 1});
    rst_at = (rst_word >= 0) ? k + 1 + rst_word : -1;

    for (int cyc = 0; ; cyc++) begin
      @(posedge clk);
      #1;
      srise    = (cyc < L) ? p_r[cyc] : 8'h00;
      sfall    = (cyc < L) ? p_f[cyc] : 8'h00;
      // Pulses that must be ignored: force in IDLE, arm during capture.
      arm      = (cyc == a) || (cyc == k + 10);
      force_t  = (cyc == f) || (f >= 0 && cyc == 0);
      rst_n    = (cyc != rst_at);
      rd_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (cyc == rst_at) begin
        chk(state == 2'd0 && !rd_valid, "reset_abort", {29'd0, rd_valid, state}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        return;
      end
      if (cyc <= k + DEPTH + 1) begin
        if      (cyc <= a)         exp_st = 0;
        else if (cyc <= k + 1)     exp_st = 1;
        else if (cyc <= k + DEPTH) exp_st = 2;
        else                       exp_st = 3;
        chk(state == 2'(exp_st), "state_seq", 32'(state), 32'(exp_st));
      end
`ifdef ADC_CAPTURE_TIMESTAMP_EN
      if (cyc == k + 1) exp_tt = 32'(edges);
`endif
      if (cyc > k + DEPTH + 1 && sb.size() == 0 && state == 2'd0) break;
      if (cyc > 4000) begin
        chk(1'b0, "frame_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        break;
      end
    end
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    chk(trig_time == exp_tt, "trig_time", trig_time, exp_tt);
`endif
    arm = 0; force_t = 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < L; i++) begin
      p_r[i] = 8'($urandom);
      p_f[i] = 8'($urandom);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(state == 2'd0, "rst_state", 32'(state), 32'd0);
    chk(!rd_valid && !rd_last, "rst_valid_last", {30'd0, rd_valid, rd_last}, 32'd0);
    chk(rd_data == 16'h0, "rst_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp, rising through 0x80 on a pair boundary.
    for (int i = 0; i < L; i++) begin
      p_r[i] = 8'(2 * i);
      p_f[i] = 8'(2 * i + 1);
    end
    run_scn(2, -1, -1, 1'b0, 8'h80, 1'b0);

    // Crossing between previous fall (0x7F) and next rise (0x80).
    fill_rand();
    for (int i = 0; i < 10; i++) begin
      p_r[i] = 8'h10;
      p_f[i] = 8'h10;
    end
    p_r[10] = 8'h20; p_f[10] = 8'h7F;
    p_r[11] = 8'h80; p_f[11] = 8'h90;
    run_scn(2, -1, -1, 1'b1, 8'h80, 1'b0);

    // Constant input, forced trigger 5 cycles after arm.
    for (int i = 0; i < L; i++) begin
      p_r[i] = 8'h10;
      p_f[i] = 8'h10;
    end
    run_scn(2, 7, -1, 1'b0, 8'h80, 1'b0);

    // Random data, falling slope, random level and back-pressure.
    fill_rand();
    run_scn(3, 300, -1, 1'b1, 8'($urandom_range(8'h40, 8'hC0)), 1'b1);

    // Reset mid-capture at word 100, then a clean frame.
    fill_rand();
    run_scn(2, 5, 100, 1'b1, 8'h80, 1'b0);
    fill_rand();
    run_scn(2, 400, -1, 1'b1, 8'($urandom_range(8'h20, 8'hE0)), 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
